// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage with a private instruction memory.
// A three-state controller (IDLE -> FETCH -> HALT) drives the program
// counter. In FETCH the word at imem[pc[31:2]] is presented with no added
// latency. The all-ones word halts the fetcher until the next reset.
//
// Optional feature macro: IFETCH_PERF_CNT_EN
//   When defined, the output fetch_count counts unstalled valid fetches.
//
// Parameters
//   IMEM_DEPTH  number of 32-bit words in the instruction memory (>= 2)
//   RESET_PC    PC value loaded on reset
//
// Ports
//   clock          rising-edge clock for all state
//   reset          synchronous active-high reset
//   start          leave IDLE and begin fetching
//   stall          hold PC and outputs (downstream hazard)
//   branch_taken   redirect PC to branch_target (wins over stall)
//   branch_target  redirect address, bits [1:0] ignored
//   imem_wr_en     program-load write strobe
//   imem_wr_addr   word address of the write
//   imem_wr_data   word to write
//   instr_out      fetched instruction (0 outside FETCH or out of range)
//   pc_out         address of instr_out (the PC register)
//   valid_out      high while in FETCH
//   halted         high while in HALT
//   fetch_count    (IFETCH_PERF_CNT_EN only) count of unstalled fetches
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_target,
  input  logic                          imem_wr_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_wr_addr,
  input  logic [31:0]                   imem_wr_data,
  output logic [31:0]                   instr_out,
  output logic [31:0]                   pc_out,
  output logic                          valid_out,
`ifdef IFETCH_PERF_CNT_EN
  output logic                          halted,
  output logic [31:0]                   fetch_count
`else
  output logic                          halted
`endif
);

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  // Memory depth expressed in the widths it is compared against. The write
  // comparison uses one extra bit so a power-of-two depth does not truncate.
  localparam logic [29:0]     DEPTH_WORDS = 30'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DEPTH_WADDR = (ADDR_W + 1)'(IMEM_DEPTH);

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q;
  logic        halted_q;

  // -------------------------------------------------------------------------
  // Instruction memory: synchronous write, asynchronous read so the fetched
  // word appears in the same cycle the PC points at it. Contents survive
  // reset; only the write strobe is suppressed while reset is high.
  // -------------------------------------------------------------------------
  logic [31:0] imem [IMEM_DEPTH];

  logic wr_in_range;
  assign wr_in_range = ({1'b0, imem_wr_addr} < DEPTH_WADDR);

  always_ff @(posedge clock) begin
    if (!reset && imem_wr_en && wr_in_range) begin
      imem[imem_wr_addr] <= imem_wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Fetch read path
  // -------------------------------------------------------------------------
  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;

  assign rd_in_range = (pc_q[31:2] < DEPTH_WORDS);
  assign rd_idx      = pc_q[ADDR_W+1:2];
  assign rd_word     = rd_in_range ? imem[rd_idx] : 32'h0;

  // valid_q tracks state==FETCH exactly, so it doubles as the read enable.
  assign instr_out = valid_q ? rd_word : 32'h0;

  // -------------------------------------------------------------------------
  // Next-state and next-PC logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Branch redirect wins even over a stall; masking with ~3 drops the
        // byte offset of the target.
        if (branch_taken) begin
          pc_d = branch_target & ~32'h3;
        end else if (!stall) begin
          pc_d = pc_q + 32'd4;  // wraps naturally at 2^32
        end
        // The halt word is consumed only on an unstalled, non-redirected
        // cycle, so it is seen downstream exactly once.
        if (!stall && !branch_taken && (instr_out == HALT_WORD)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;  // only reset leaves HALT
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register with registered status outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= (state_d == ST_FETCH);
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign pc_out    = pc_q;
  assign valid_out = valid_q;
  assign halted    = halted_q;

`ifdef IFETCH_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counter: one tick per fetch accepted downstream.
  // -------------------------------------------------------------------------
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (valid_q && !stall) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_wr_en;
  logic [5:0]  imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        halted;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(
    .IMEM_DEPTH (64),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_wr_en    (imem_wr_en),
    .imem_wr_addr  (imem_wr_addr),
    .imem_wr_data  (imem_wr_data),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out),
`ifdef IFETCH_PERF_CNT_EN
    .halted        (halted),
    .fetch_count   (fetch_count)
`else
    .halted        (halted)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input logic h);
    chk({tag, ".pc"},     pc_out,           pc);
    chk({tag, ".instr"},  instr_out,        ins);
    chk({tag, ".valid"},  {31'h0, valid_out}, {31'h0, v});
    chk({tag, ".halted"}, {31'h0, halted},    {31'h0, h});
    $display("step %-14s pc=%h instr=%h valid=%0b halted=%0b", tag, pc_out, instr_out, valid_out, halted);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    imem_wr_en   = 1'b1;
    imem_wr_addr = a;
    imem_wr_data = d;
    step();
    imem_wr_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_wr_en = 1'b0; imem_wr_addr = 6'd0; imem_wr_data = 32'h0;

    // Reset with other inputs active; reset must dominate.
    start = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    step();
    chk_out("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0;

    // Word 8 written normally, then a write to it under reset must be dropped.
    reset = 1'b0;
    wr(6'd8, 32'h0000_0088);
    reset = 1'b1;
    wr(6'd8, 32'h0000_0BAD);
    chk_out("reset_wr", 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    // Program load in IDLE.
    wr(6'd0, 32'd5);
    wr(6'd1, 32'd10);
    wr(6'd2, 32'd15);
    wr(6'd3, 32'h0000_0033);
    chk_out("idle_loaded", 32'h0, 32'h0, 1'b0, 1'b0);

    // Sequential fetch.
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("fetch0", 32'h0, 32'd5, 1'b1, 1'b0);
    step();
    chk_out("fetch4", 32'h4, 32'd10, 1'b1, 1'b0);

    // Stall for three cycles holds PC and instruction.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stall4", 32'h4, 32'd10, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    chk_out("fetch8", 32'h8, 32'd15, 1'b1, 1'b0);

    // Branch with stall: branch wins, low bits dropped; word 8 kept 0x88.
    branch_taken = 1'b1; branch_target = 32'h23; stall = 1'b1;
    step();
    chk_out("br_stall", 32'h20, 32'h88, 1'b1, 1'b0);

    // Branch past the end of memory: NOP but still valid.
    stall = 1'b0; branch_target = 32'h100;
    step();
    chk_out("br_oor", 32'h100, 32'h0, 1'b1, 1'b0);
    branch_taken = 1'b0;
    step();
    chk_out("oor_next", 32'h104, 32'h0, 1'b1, 1'b0);

    // PC wrap at 2^32.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    step();
    chk_out("br_top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);
    branch_taken = 1'b0;
    step();
    chk_out("wrap", 32'h0, 32'd5, 1'b1, 1'b0);

    // Go to word 3, then overwrite it while stalled: old word this cycle.
    branch_taken = 1'b1; branch_target = 32'hC;
    step();
    chk_out("br_c", 32'hC, 32'h33, 1'b1, 1'b0);
    branch_taken = 1'b0; stall = 1'b1;
    imem_wr_en = 1'b1; imem_wr_addr = 6'd3; imem_wr_data = 32'hFFFF_FFFF;
    #1;
    chk("same_cycle_old", instr_out, 32'h33);
    step();
    imem_wr_en = 1'b0;
    // Halt word visible, but stalled so no halt yet.
    chk_out("halt_stalled", 32'hC, 32'hFFFF_FFFF, 1'b1, 1'b0);
    stall = 1'b0;
    step();
    chk("halt.halted", {31'h0, halted}, 32'h1);
    chk("halt.valid",  {31'h0, valid_out}, 32'h0);
    chk("halt.instr",  instr_out, 32'h0);

    // HALT ignores start / branch / stall.
    start = 1'b1; branch_taken = 1'b1; branch_target = 32'h0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_hold.halted", {31'h0, halted}, 32'h1);
      chk("halt_hold.valid",  {31'h0, valid_out}, 32'h0);
      chk("halt_hold.instr",  instr_out, 32'h0);
    end
    start = 1'b0; branch_taken = 1'b0; stall = 1'b0;

    // Reset from HALT.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("halt_reset", 32'h0, 32'h0, 1'b0, 1'b0);

    // Memory survives reset; reset mid-FETCH returns to IDLE.
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("refetch0", 32'h0, 32'd5, 1'b1, 1'b0);
    step();
    chk_out("refetch4", 32'h4, 32'd10, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("fetch_reset", 32'h0, 32'h0, 1'b0, 1'b0);

    // Four unstalled fetches plus two stalled cycles, ending in HALT.
`ifdef IFETCH_PERF_CNT_EN
    chk("cnt_reset", fetch_count, 32'd0);
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    step();
    chk_out("cnt_pc12", 32'hC, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step();
    chk("cnt_halted", {31'h0, halted}, 32'h1);
`ifdef IFETCH_PERF_CNT_EN
    chk("cnt_four", fetch_count, 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("cnt_cleared", fetch_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, number of 32-bit instruction words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  leave IDLE and begin fetching.
REQ-007 stall  input  1  hold PC and outputs (hazard from downstream).
REQ-008 branch_taken  input  1  redirect PC to branch_target.
REQ-009 branch_target  input  32  redirect address; bits [1:0] ignored.
REQ-010 imem_wr_en  input  1  program-load write strobe.
REQ-011 imem_wr_addr  input  $clog2(IMEM_DEPTH)  word address of write.
REQ-012 imem_wr_data  input  32  word to write.
REQ-013 instr_out  output  32  fetched instruction, drives if_id_buffer instr_in.
REQ-014 pc_out  output  32  address of instr_out, drives if_id_buffer pc_in.
REQ-015 valid_out  output  1  instr_out/pc_out hold a real fetch.
REQ-016 halted  output  1  high while in HALT state.

Function
REQ-017 SHALL implement states IDLE, FETCH, HALT in a registered state machine.
REQ-018 IDLE -> FETCH on clock edge with start=1; otherwise stays IDLE.
REQ-019 FETCH -> HALT on edge where instr_out==32'hFFFF_FFFF, stall=0, branch_taken=0.
REQ-020 HALT SHALL be exited only by reset; start, branch_taken, stall ignored.
REQ-021 PC register SHALL update only in FETCH, priority: branch_taken > stall > PC+4.
REQ-022 branch_taken SHALL load {branch_target[31:2],2'b00}, even with stall=1.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-024 instr_out SHALL be combinational read of imem[pc[31:2]] (zero added latency) in FETCH.
REQ-025 If pc[31:2] >= IMEM_DEPTH, instr_out SHALL be 32'h0 (NOP).
REQ-026 In IDLE and HALT, instr_out SHALL be 32'h0 and valid_out 0.
REQ-027 pc_out SHALL equal the PC register in all states.
REQ-028 valid_out SHALL be 1 in FETCH regardless of stall; the halt word is emitted with valid_out=1 for exactly one unstalled cycle.
REQ-029 halted SHALL equal (state==HALT).
REQ-030 imem writes SHALL occur on the clock edge in any state; same-cycle read returns old word, new word visible next cycle.

Reset
REQ-031 On reset: state=IDLE, PC=RESET_PC, valid_out=0, halted=0, instr_out=0.
REQ-032 Reset SHALL override start, stall, branch_taken and imem_wr_en in the same cycle; no memory write occurs.
REQ-033 Reset SHALL NOT clear imem contents; program reload is not required after reset.
REQ-034 Reset asserted mid-FETCH or in HALT SHALL return to IDLE on the next edge.

Configuration
REQ-035 Macro IFETCH_PERF_CNT_EN, when defined, SHALL add output fetch_count (32 bits).
REQ-036 With IFETCH_PERF_CNT_EN, fetch_count SHALL increment on each edge with valid_out=1 and stall=0, wrap at 2^32, clear to 0 on reset.
REQ-037 Without IFETCH_PERF_CNT_EN, fetch_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-038 Reset, load imem[0..2]=5,10,15, pulse start -> cycles show pc_out 0,4,8 with instr_out 5,10,15, valid_out=1.
REQ-039 In FETCH at pc=4 hold stall=1 for 3 cycles -> pc_out stays 4, instr_out stays 10, then resumes at 8.
REQ-040 branch_taken=1, branch_target=32'h23 with stall=1 at pc=8 -> next pc_out=32'h20.
REQ-041 imem[3]=32'hFFFF_FFFF -> pc_out 12 valid one cycle, then halted=1, valid_out=0, instr_out=0; start/branch ignored; reset -> IDLE, pc_out=0.
REQ-042 Branch to 32'h100 with IMEM_DEPTH=64 -> instr_out=0, valid_out=1, next pc_out=32'h104.
REQ-043 With IFETCH_PERF_CNT_EN, 4 unstalled fetches plus 2 stalled cycles -> fetch_count=4; reset -> 0.
